// File: rtl/counter_updown_if.sv
// counter_updown_if: control and status bundle for counter_updown.
// master drives the controls and observes the count; slave is the counter.
interface counter_updown_if #(
    parameter int WIDTH = 4
) ();
    logic             ctr_rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             err;

    modport master (
        output ctr_rst, load, load_val, en, up,
        input  out, tc, err
    );

    modport slave (
        input  ctr_rst, load, load_val, en, up,
        output out, tc, err
    );
endinterface

// File: rtl/counter_updown.sv
// counter_updown: parametrised up/down counter over 0..MAX with synchronous
// clear, parallel load (illegal loads flagged on err), and a combinational
// terminal-count strobe.
// Build option: define COUNTER_UPDOWN_SAT_EN to saturate at the bounds
// instead of wrapping. Load, clear, tc and err are identical in both builds.
module counter_updown #(
    parameter int              WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active low
    counter_updown_if.slave   bus
);

    // Elaboration-time legality of the configuration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_updown: WIDTH must be within 1..32");
    end
    if (MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_updown: MAX must not exceed 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bad_load;

    // Next-count selection in priority order: clear, load, count, hold.
    always_comb begin
        w_at_max   = (r_count == MAX_V);
        w_at_zero  = (r_count == '0);
        w_bad_load = bus.load && (bus.load_val > MAX_V);
        w_next     = r_count;
        if (bus.ctr_rst) begin
            w_next = '0;
        end else if (bus.load) begin
            // An out-of-range load leaves the count untouched.
            if (!w_bad_load) w_next = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
`ifdef COUNTER_UPDOWN_SAT_EN
                w_next = w_at_max ? MAX_V : r_count + WIDTH'(1);
`else
                w_next = w_at_max ? '0 : r_count + WIDTH'(1);
`endif
            end else begin
`ifdef COUNTER_UPDOWN_SAT_EN
                w_next = w_at_zero ? '0 : r_count - WIDTH'(1);
`else
                w_next = w_at_zero ? MAX_V : r_count - WIDTH'(1);
`endif
            end
        end
    end

    // Count register; reset clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_count <= '0;
        else      r_count <= w_next;
    end

    assign bus.out = r_count;
    // tc marks an enabled step that crosses (or, saturating, sits on) a bound.
    assign bus.tc  = bus.en & ~bus.ctr_rst & ~bus.load &
                     ((bus.up & w_at_max) | (~bus.up & w_at_zero));
    // A clear masks a bad load, so err only reports loads that were refused.
    assign bus.err = ~bus.ctr_rst & w_bad_load;

endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed vectors against three counter configurations
// (4-bit/MAX=9, 1-bit toggle, 3-bit/MAX=0). Stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them.
module tb_counter_updown;

`ifdef COUNTER_UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;

    counter_updown_if #(.WIDTH(4)) ia ();
    counter_updown_if #(.WIDTH(1)) ib ();
    counter_updown_if #(.WIDTH(3)) ic ();

    counter_updown #(.WIDTH(4), .MAX(9)) u_a (.clk(clk), .rst(rst), .bus(ia));
    counter_updown #(.WIDTH(1), .MAX(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    counter_updown #(.WIDTH(3), .MAX(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        int         id;
        string      nm;
        logic [3:0] o;
        logic       t;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input string nm, input logic [3:0] o,
                            input logic t, input logic e);
        exp_t x;
        x.id = id; x.nm = nm; x.o = o; x.t = t; x.e = e;
        q.push_back(x);
    endtask

    // Monitor: outputs are settled mid-cycle; compare every pending expectation.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t       x;
            logic [3:0] ao;
            logic       at;
            logic       ae;
            x = q.pop_front();
            case (x.id)
                0:       begin ao = ia.out;              at = ia.tc; ae = ia.err; end
                1:       begin ao = {3'b000, ib.out};    at = ib.tc; ae = ib.err; end
                default: begin ao = {1'b0, ic.out};      at = ic.tc; ae = ic.err; end
            endcase
            checks++;
            if (ao !== x.o || at !== x.t || ae !== x.e) begin
                failures++;
                $display("FAIL %s dut%0d: got out=%0d tc=%b err=%b, want out=%0d tc=%b err=%b",
                         x.nm, x.id, ao, at, ae, x.o, x.t, x.e);
            end
        end
    end

    initial begin
        int v;
        rst = 1'b0;
        ia.ctr_rst = 0; ia.load = 0; ia.load_val = '0; ia.en = 0; ia.up = 0;
        ib.ctr_rst = 0; ib.load = 0; ib.load_val = '0; ib.en = 0; ib.up = 0;
        ic.ctr_rst = 0; ic.load = 0; ic.load_val = '0; ic.en = 0; ic.up = 0;
        repeat (2) cyc();

        // Reset held: count 0, tc follows en & ~up.
        cyc(); ia.en = 1; ia.up = 0;
        push_exp(0, "rst_hold_tc", 0, 1, 0);
        cyc(); ia.en = 0; rst = 1; ia.load = 1; ia.load_val = 5;
        push_exp(0, "rst_rel", 0, 0, 0);
        cyc(); ia.load = 0;
        push_exp(0, "load5", 5, 0, 0);
        // Asynchronous clear mid-cycle, checked before the next rising edge.
        cyc(); rst = 0;
        push_exp(0, "async_rst", 0, 0, 0);
        cyc(); rst = 1; ia.en = 1; ia.up = 1;
        push_exp(0, "rst_release", 0, 0, 0);

        // Count up across MAX=9.
        for (int i = 1; i <= 11; i++) begin
            cyc();
            v = SAT ? ((i > 9) ? 9 : i) : (i % 10);
            push_exp(0, "wrap_up", 4'(v), (v == 9), 0);
        end

        // Load 1, then count down across zero.
        cyc(); ia.load = 1; ia.load_val = 1; ia.up = 0;
        push_exp(0, "ld1", SAT ? 4'd9 : 4'd2, 0, 0);
        cyc(); ia.load = 0;
        push_exp(0, "dn1", 1, 0, 0);
        cyc(); push_exp(0, "dn0", 0, 1, 0);
        cyc(); push_exp(0, "dn_wrap", SAT ? 4'd0 : 4'd9, SAT, 0);
        cyc(); push_exp(0, "dn8", SAT ? 4'd0 : 4'd8, SAT, 0);

        // Load legality.
        cyc(); ia.en = 0; ia.load = 1; ia.load_val = 3;
        push_exp(0, "ld3", SAT ? 4'd0 : 4'd7, 0, 0);
        cyc(); ia.load_val = 12;
        push_exp(0, "bad_ld", 3, 0, 1);
        cyc(); ia.load_val = 7;
        push_exp(0, "good_ld", 3, 0, 0);
        cyc(); ia.load_val = 6;
        push_exp(0, "ld7", 7, 0, 0);

        // Priority: clear over bad load and enable; load over enable.
        cyc(); ia.ctr_rst = 1; ia.load_val = 12; ia.en = 1; ia.up = 1;
        push_exp(0, "prio_clr", 6, 0, 0);
        cyc(); ia.ctr_rst = 0; ia.load_val = 4;
        push_exp(0, "clr_done", 0, 0, 0);
        cyc(); ia.load = 0; ia.en = 0;
        push_exp(0, "ld_over_en", 4, 0, 0);

        // 1-bit, MAX=1: toggle flop.
        cyc(); ib.en = 1; ib.up = 1;
        push_exp(1, "tog0", 0, 0, 0);
        cyc(); push_exp(1, "tog1", 1, 1, 0);
        cyc(); push_exp(1, "tog2", SAT ? 4'd1 : 4'd0, SAT, 0);
        cyc(); push_exp(1, "tog3", 1, 1, 0);
        cyc(); ib.en = 0;
        push_exp(1, "tog_hold", SAT ? 4'd1 : 4'd0, 0, 0);

        // MAX=0: count pinned at 0, tc = en while load/clear low.
        cyc(); ic.en = 1; ic.up = 1;
        push_exp(2, "m0_up", 0, 1, 0);
        cyc(); ic.up = 0;
        push_exp(2, "m0_dn", 0, 1, 0);
        cyc(); ic.load = 1; ic.load_val = 0;
        push_exp(2, "m0_ld", 0, 0, 0);
        cyc(); ic.load_val = 3;
        push_exp(2, "m0_bad", 0, 0, 1);
        cyc(); ic.load = 0; ic.en = 0;
        push_exp(2, "m0_idle", 0, 0, 0);

        repeat (2) cyc();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_updown.md
# counter_updown

Parametrised up/down counter with synchronous clear, parallel load, a programmable terminal value and a terminal-count strobe. It is the next generation of the team's fixed 2-bit enable/clear counter. It serves as the general-purpose sequencing counter for control FSMs, cycle timers and modulo-N address generation. Terminal-value overflow either wraps or saturates, selected at compile time.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MAX, 2**WIDTH-1: terminal value. Count range is 0..MAX. MAX must be at most 2**WIDTH-1 (elaboration constraint).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset. Low forces count to 0 immediately.
- ctr_rst  in  1  synchronous clear; highest-priority control.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down. Sampled only when counting.
- out  out  WIDTH  current count (register output).
- tc  out  1  terminal-count strobe (combinational).
- err  out  1  illegal-load flag (combinational).

## Operation
- State is one WIDTH-bit count register. out = count.
- Control priority each cycle:
  - ctr_rst=1: next = 0.
  - Else load=1 with load_val <= MAX: next = load_val.
  - Else load=1 with load_val > MAX: next = count (hold) and err=1.
  - Else en=1, up=1: next = count+1, or 0 if count==MAX (wrap).
  - Else en=1, up=0: next = count-1, or MAX if count==0 (wrap).
  - Else: hold.
- Arithmetic is WIDTH-bit modulo (MAX+1). The value never exceeds MAX once it has left reset.
- tc = en & ~ctr_rst & ~load & ((up & count==MAX) | (~up & count==0)). tc flags that the current enabled step crosses the boundary.
- err is asserted only in the illegal-load case. It is 0 in all other cases, including when ctr_rst masks a bad load.
- WIDTH=1, MAX=1 degenerates to a toggle flop. MAX=0 holds 0 permanently, and tc=en whenever load and ctr_rst are low.

## Timing
- Reset values: out=0. tc follows its equation from count=0, so tc=en&~up while reset is held with controls low. err=0 unless an illegal load is presented.
- rst asserted at any time, including mid-count or during a load, clears count asynchronously. The first update after deassertion occurs on the first rising clk edge with rst high.
- Latency: ctr_rst, load and en take effect on out one clock after being sampled high.
- tc and err are combinational: valid in the same cycle as their inputs, no registered delay.
- Direction change takes effect on the same edge it is sampled. There is no turnaround cycle.
- Simultaneous ctr_rst and load: clear wins and err=0. Simultaneous load and en: the load wins.

## Configuration
- Macro COUNTER_UPDOWN_SAT_EN.
- Defined: saturating mode.
  - Up at count==MAX holds MAX; down at 0 holds 0.
  - tc is still asserted by the same equation, repeating every enabled cycle at the bound.
- Undefined (default): wrap mode as described in Operation.
- Load, clear and err behaviour are identical in both builds.

## Test plan
- Reset: drive rst=0 mid-count with count=5 (WIDTH=4) -> out=0 immediately, without waiting for a clk edge. Release rst with en=1, up=1 -> out=1 after the first rising edge.
- Wrap-up: WIDTH=4, MAX=9, en=1, up=1 for 12 cycles from 0 -> out steps 0..9,0,1. tc=1 only in the cycle where out=9. In the SAT build -> out sticks at 9 and tc stays 1.
- Wrap-down: MAX=9, load_val=1, load then en=1, up=0 -> out 1,0,9,8. tc=1 only in the cycle where out=0.
- Load legality: MAX=9, load=1, load_val=12 with out=3 -> err=1 and out stays 3. load_val=7 -> err=0 and out=7 next cycle.
- Priority: ctr_rst=1, load=1, load_val=12, en=1 with out=6 -> err=0, tc=0, out=0 next cycle. Then load=1, en=1, load_val=4 -> out=4.
- Degenerate: WIDTH=1, MAX=1, en=1 -> out toggles 0,1,0 and tc=1 every cycle where out=1 (up=1).
